// File: rtl/sccomp_mem_bridge.sv
// Memory-side bridge between the CPU core and imem/dmem: segment-based address
// mapping, fixed-latency fetch, wait-stated data FSM with byte lanes. Optional checks: ACCESS_ERR_EN.
module sccomp_mem_bridge #(
  parameter logic [31:0] IBASE = 32'h00400000,
  parameter logic [31:0] DBASE = 32'h10010000,
  parameter int          IAW   = 11,
  parameter int          DAW   = 11,
  parameter int          DWAIT = 1
) (
  input  logic           clk_in,
  input  logic           reset,
  input  logic [31:0]    i_addr,
  input  logic           i_req,
  output logic [31:0]    i_rdata,
  output logic           i_ready,
  input  logic [31:0]    d_addr,
  input  logic           d_req,
  input  logic           d_we,
  input  logic [3:0]     d_be,
  input  logic [31:0]    d_wdata,
  output logic [31:0]    d_rdata,
  output logic           d_ready,
  output logic           d_err,
  output logic [IAW-1:0] imem_addr,
  input  logic [31:0]    imem_rdata,
  output logic [DAW-1:0] dmem_addr,
  output logic           dmem_we,
  output logic [3:0]     dmem_be,
  output logic [31:0]    dmem_wdata,
  input  logic [31:0]    dmem_rdata
);

  localparam logic [3:0] DWAIT_L = 4'(DWAIT);

  typedef enum logic [1:0] {
    D_IDLE,
    D_WAIT,
    D_ACC,
    D_RESP
  } d_state_t;

  d_state_t       d_state_reg, d_state_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [DAW-1:0] addr_reg, addr_next;
  logic           we_reg, we_next;
  logic [3:0]     be_reg, be_next;
  logic [31:0]    wdata_reg, wdata_next;
  logic           err_reg, err_next;
  logic [31:0]    d_rdata_reg, d_rdata_next;
  logic [31:0]    i_rdata_reg;
  logic           i_ready_reg;

  logic [31:0]    i_off;
  logic [31:0]    d_off;
  logic           i_in_range;
  logic           d_fault;
  logic           unused_off_bits;

  // Segment offsets are plain 32-bit unsigned differences; a negative offset wraps high.
  assign i_off = i_addr - IBASE;
  assign d_off = d_addr - DBASE;

`ifdef ACCESS_ERR_EN
  logic d_in_range;
  logic d_misalign;

  assign i_in_range = (i_off >> (IAW + 2)) == 32'd0;
  assign d_in_range = (d_off >> (DAW + 2)) == 32'd0;
  assign d_misalign = (d_be == 4'b1111) && (d_addr[1:0] != 2'b00);
  assign d_fault    = !d_in_range || d_misalign;
`else
  assign i_in_range = 1'b1;
  assign d_fault    = 1'b0;
`endif

  assign unused_off_bits = ^{i_off[1:0], i_off[31:IAW+2], d_off[1:0], d_off[31:DAW+2]};

  // Fetch path: imem is combinational, so the word is captured one cycle after the request.
  assign imem_addr = reset ? i_off[IAW+1:2] : '0;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      i_ready_reg <= 1'b0;
      i_rdata_reg <= '0;
    end else begin
      i_ready_reg <= i_req;
      if (i_req) begin
        i_rdata_reg <= i_in_range ? imem_rdata : 32'h00000000;
      end
    end
  end

  assign i_ready = i_ready_reg;
  assign i_rdata = i_rdata_reg;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      d_state_reg <= D_IDLE;
      cnt_reg     <= '0;
      addr_reg    <= '0;
      we_reg      <= 1'b0;
      be_reg      <= '0;
      wdata_reg   <= '0;
      err_reg     <= 1'b0;
      d_rdata_reg <= '0;
    end else begin
      d_state_reg <= d_state_next;
      cnt_reg     <= cnt_next;
      addr_reg    <= addr_next;
      we_reg      <= we_next;
      be_reg      <= be_next;
      wdata_reg   <= wdata_next;
      err_reg     <= err_next;
      d_rdata_reg <= d_rdata_next;
    end
  end

  always_comb begin
    d_state_next = d_state_reg;
    cnt_next     = cnt_reg;
    addr_next    = addr_reg;
    we_next      = we_reg;
    be_next      = be_reg;
    wdata_next   = wdata_reg;
    err_next     = err_reg;
    d_rdata_next = d_rdata_reg;
    case (d_state_reg)
      D_IDLE: begin
        if (d_req) begin
          addr_next  = d_off[DAW+1:2];
          we_next    = d_we;
          be_next    = d_be;
          wdata_next = d_wdata;
          err_next   = d_fault;
          cnt_next   = DWAIT_L;
          // A faulting access never touches dmem and answers right away.
          if (d_fault) begin
            d_state_next = D_RESP;
          end else if (DWAIT_L != 4'd0) begin
            d_state_next = D_WAIT;
          end else begin
            d_state_next = D_ACC;
          end
        end
      end
      D_WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg <= 4'd1) begin
          d_state_next = D_ACC;
        end
      end
      D_ACC: begin
        if (!we_reg) begin
          d_rdata_next = dmem_rdata;
        end
        d_state_next = D_RESP;
      end
      D_RESP: begin
        d_state_next = D_IDLE;
      end
      default: begin
        d_state_next = D_IDLE;
      end
    endcase
  end

  // Strobes are qualified by reset so an abort in D_ACC cannot leak a partial write.
  assign dmem_we    = reset && (d_state_reg == D_ACC) && we_reg;
  assign d_ready    = reset && (d_state_reg == D_RESP);
  assign d_err      = d_ready && err_reg;
  assign dmem_addr  = addr_reg;
  assign dmem_wdata = wdata_reg;
  assign d_rdata    = d_rdata_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign dmem_be[gi] = dmem_we & be_reg[gi];
  end

endmodule

// File: tb/tb_sccomp_mem_bridge.sv
// Scoreboard bench for sccomp_mem_bridge: one instance with DWAIT=1, one with DWAIT=3.
module tb_sccomp_mem_bridge;

  logic        clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        reset;
  logic [31:0] i_addr;
  logic        i_req;
  logic [31:0] d_addr;
  logic        d_req;
  logic        d1_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        init_mem;

  logic [31:0] i_rdata, d_rdata, imem_rdata, dmem_rdata, dmem_wdata;
  logic        i_ready, d_ready, d_err, dmem_we;
  logic [10:0] imem_addr, dmem_addr;
  logic [3:0]  dmem_be;

  logic [31:0] i1_rdata_unused, d1_rdata, imem1_rdata, dmem1_rdata, dmem1_wdata;
  logic        i1_ready_unused, d1_ready, d1_err_unused, dmem1_we;
  logic [10:0] imem1_addr_unused, dmem1_addr;
  logic [3:0]  dmem1_be;

  logic [31:0] dmem  [0:2047];
  logic [31:0] dmem1 [0:2047];
  logic [31:0] exp_q [$];

  int checks = 0;
  int failures = 0;

  sccomp_mem_bridge #(.DWAIT(1)) dut (
    .clk_in(clk_in), .reset(reset),
    .i_addr(i_addr), .i_req(i_req), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_addr(d_addr), .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  sccomp_mem_bridge #(.DWAIT(3)) dut1 (
    .clk_in(clk_in), .reset(reset),
    .i_addr(i_addr), .i_req(i_req), .i_rdata(i1_rdata_unused), .i_ready(i1_ready_unused),
    .d_addr(d_addr), .d_req(d1_req), .d_we(d_we), .d_be(d_be), .d_wdata(d_wdata),
    .d_rdata(d1_rdata), .d_ready(d1_ready), .d_err(d1_err_unused),
    .imem_addr(imem1_addr_unused), .imem_rdata(imem1_rdata),
    .dmem_addr(dmem1_addr), .dmem_we(dmem1_we), .dmem_be(dmem1_be),
    .dmem_wdata(dmem1_wdata), .dmem_rdata(dmem1_rdata)
  );

  // imem word k holds A000_0000 | k; dmem models are byte-writable arrays.
  assign imem_rdata  = 32'hA0000000 | 32'(imem_addr);
  assign imem1_rdata = 32'h00000000;
  assign dmem_rdata  = dmem[dmem_addr];
  assign dmem1_rdata = dmem1[dmem1_addr];

  always @(posedge clk_in) begin
    if (init_mem) begin
      for (int k = 0; k < 2048; k++) begin
        dmem[k]  <= 32'h0;
        dmem1[k] <= 32'h0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_we && dmem_be[b]) dmem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
        if (dmem1_we && dmem1_be[b]) dmem1[dmem1_addr][8*b +: 8] <= dmem1_wdata[8*b +: 8];
      end
    end
  end

  function automatic logic [31:0] fetch_model(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h00400000;
`ifdef ACCESS_ERR_EN
    if (off >= 32'h00002000) return 32'h0;
`endif
    return 32'hA0000000 | ((off >> 2) & 32'h7FF);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Issue one data access to either instance and record what the DUT did.
  task automatic run_data(input bit use1, input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata,
                          output int ready_at, output int we_cnt, output logic [31:0] rdata,
                          output logic err, output logic [10:0] we_addr, output logic [3:0] we_be);
    d_addr = addr; d_we = we; d_be = be; d_wdata = wdata;
    if (use1) d1_req = 1'b1; else d_req = 1'b1;
    ready_at = 0; we_cnt = 0; rdata = 32'h0; err = 1'b0; we_addr = '0; we_be = '0;
    for (int n = 1; n <= 12 && ready_at == 0; n++) begin
      tick();
      d_req = 1'b0; d1_req = 1'b0;
      if (use1 ? dmem1_we : dmem_we) begin
        we_cnt++;
        we_addr = use1 ? dmem1_addr : dmem_addr;
        we_be   = use1 ? dmem1_be : dmem_be;
      end
      if (use1 ? d1_ready : d_ready) begin
        ready_at = n;
        rdata = use1 ? d1_rdata : d_rdata;
        err = use1 ? 1'b0 : d_err;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; init_mem = 1'b1;
    i_req = 1'b1; i_addr = 32'h00400008;
    d_req = 1'b1; d1_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
    d_wdata = 32'hFFFFFFFF; d_addr = 32'h10010000;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({dmem_we, dmem1_we} !== 2'b00) begin
        failures++; $display("FAIL reset_we cycle %0d: got %b required 00", c, {dmem_we, dmem1_we});
      end
      checks++;
      if ({i_ready, d_ready, d_err, i_rdata, d_rdata, dmem_be, dmem_wdata, dmem_addr, imem_addr} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: i_ready=%b d_ready=%b d_err=%b i_rdata=%h d_rdata=%h be=%h wdata=%h daddr=%h iaddr=%h required all zero",
                 c, i_ready, d_ready, d_err, i_rdata, d_rdata, dmem_be, dmem_wdata, dmem_addr, imem_addr);
      end
    end
    d_req = 1'b0; d1_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
    init_mem = 1'b0; reset = 1'b1;
    tick();
    checks++;
    if ({d_ready, dmem_we, d1_ready, dmem1_we} !== 4'b0000) begin
      failures++; $display("FAIL reset_release: got %b required 0000", {d_ready, dmem_we, d1_ready, dmem1_we});
    end
    $display("reset: done");
  endtask

  task automatic test_fetch();
    logic [31:0] exp;
    logic [31:0] addrs [3];
    addrs[0] = 32'h00400008; addrs[1] = 32'h0040000C; addrs[2] = 32'h00400010;
    i_addr = addrs[0]; i_req = 1'b1;
    exp_q.push_back(fetch_model(addrs[0]));
    #1;
    checks++;
    if (imem_addr !== 11'd2) begin
      failures++; $display("FAIL fetch_imem_addr: got %0d required 2", imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = exp_q.pop_front();
      if (k < 2) begin
        i_addr = addrs[k+1];
        exp_q.push_back(fetch_model(addrs[k+1]));
      end else begin
        i_req = 1'b0;
      end
      checks++;
      if (i_ready !== 1'b1 || i_rdata !== exp) begin
        failures++; $display("FAIL fetch_%0d: got ready=%b data=%h required ready=1 data=%h", k, i_ready, i_rdata, exp);
      end
      $display("fetch: addr=%h data=%h", addrs[k], i_rdata);
    end
    tick();
    checks++;
    if (i_ready !== 1'b0) begin
      failures++; $display("FAIL fetch_idle: got ready=%b required 0", i_ready);
    end
  endtask

  task automatic test_store_load();
    int ra, wc; logic [31:0] rd; logic er; logic [10:0] wa; logic [3:0] wb;
    logic [31:0] exp;
    run_data(1'b0, 32'h10010010, 1'b1, 4'hF, 32'hDEADBEEF, ra, wc, rd, er, wa, wb);
    $display("store: addr=10010010 ready_at=%0d we_cnt=%0d dmem_addr=%0d be=%b", ra, wc, wa, wb);
    checks++;
    if (ra !== 3 || wc !== 1) begin
      failures++; $display("FAIL store_timing: got ready_at=%0d we_cnt=%0d required 3 and 1", ra, wc);
    end
    checks++;
    if (wa !== 11'd4 || wb !== 4'hF || er !== 1'b0) begin
      failures++; $display("FAIL store_addr: got addr=%0d be=%b err=%b required 4 1111 0", wa, wb, er);
    end
    checks++;
    if (dmem[4] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL store_mem: got %h required deadbeef", dmem[4]);
    end
    exp_q.push_back(32'hDEADBEEF);
    run_data(1'b0, 32'h10010010, 1'b0, 4'hF, 32'h0, ra, wc, rd, er, wa, wb);
    exp = exp_q.pop_front();
    $display("load: addr=10010010 ready_at=%0d data=%h", ra, rd);
    checks++;
    if (ra !== 3 || wc !== 0 || rd !== exp) begin
      failures++; $display("FAIL load: got ready_at=%0d we_cnt=%0d data=%h required 3 0 %h", ra, wc, rd, exp);
    end
  endtask

  task automatic test_byte_store();
    int ra, wc; logic [31:0] rd; logic er; logic [10:0] wa; logic [3:0] wb;
    logic [31:0] exp;
    run_data(1'b0, 32'h10010001, 1'b1, 4'b0010, 32'h0000AB00, ra, wc, rd, er, wa, wb);
    $display("byte_store: addr=10010001 ready_at=%0d dmem_addr=%0d be=%b err=%b", ra, wa, wb, er);
    checks++;
    if (wc !== 1 || wa !== 11'd0 || wb !== 4'b0010 || er !== 1'b0) begin
      failures++; $display("FAIL byte_store: got we_cnt=%0d addr=%0d be=%b err=%b required 1 0 0010 0", wc, wa, wb, er);
    end
    checks++;
    if (d_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL rdata_hold: got %h required deadbeef", d_rdata);
    end
    exp_q.push_back(32'h0000AB00);
    run_data(1'b0, 32'h10010000, 1'b0, 4'hF, 32'h0, ra, wc, rd, er, wa, wb);
    exp = exp_q.pop_front();
    $display("load: addr=10010000 data=%h", rd);
    checks++;
    if (rd !== exp) begin
      failures++; $display("FAIL byte_readback: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_concurrent();
    int ready_at = 0;
    logic [31:0] exp_i, exp_d;
    exp_q.push_back(fetch_model(32'h00400020));
    exp_q.push_back(32'hDEADBEEF);
    i_addr = 32'h00400020; i_req = 1'b1;
    d_addr = 32'h10010010; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
    tick();
    i_req = 1'b0; d_req = 1'b0;
    exp_i = exp_q.pop_front();
    checks++;
    if (i_ready !== 1'b1 || i_rdata !== exp_i) begin
      failures++; $display("FAIL concurrent_fetch: got ready=%b data=%h required 1 %h", i_ready, i_rdata, exp_i);
    end
    for (int n = 2; n <= 12 && ready_at == 0; n++) begin
      tick();
      if (d_ready) ready_at = n;
    end
    exp_d = exp_q.pop_front();
    checks++;
    if (ready_at !== 3 || d_rdata !== exp_d) begin
      failures++; $display("FAIL concurrent_load: got ready_at=%0d data=%h required 3 %h", ready_at, d_rdata, exp_d);
    end
    $display("concurrent: fetch=%h load=%h ready_at=%0d", i_rdata, d_rdata, ready_at);
    tick();
  endtask

`ifdef ACCESS_ERR_EN
  task automatic test_errors();
    int ra, wc; logic [31:0] rd; logic er; logic [10:0] wa; logic [3:0] wb;
    run_data(1'b0, 32'h10010002, 1'b0, 4'hF, 32'h0, ra, wc, rd, er, wa, wb);
    $display("misaligned_load: ready_at=%0d err=%b data=%h", ra, er, rd);
    checks++;
    if (ra !== 1 || er !== 1'b1 || rd !== 32'hDEADBEEF) begin
      failures++; $display("FAIL misaligned_load: got ready_at=%0d err=%b data=%h required 1 1 deadbeef", ra, er, rd);
    end
    run_data(1'b0, 32'h10010006, 1'b1, 4'hF, 32'h77777777, ra, wc, rd, er, wa, wb);
    checks++;
    if (wc !== 0 || er !== 1'b1 || dmem[1] !== 32'h0) begin
      failures++; $display("FAIL misaligned_store: got we_cnt=%0d err=%b mem=%h required 0 1 0", wc, er, dmem[1]);
    end
    run_data(1'b0, 32'h10012000, 1'b0, 4'hF, 32'h0, ra, wc, rd, er, wa, wb);
    $display("range_load: ready_at=%0d err=%b", ra, er);
    checks++;
    if (ra !== 1 || er !== 1'b1) begin
      failures++; $display("FAIL range_load: got ready_at=%0d err=%b required 1 1", ra, er);
    end
    i_addr = 32'h00402000; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    checks++;
    if (i_ready !== 1'b1 || i_rdata !== 32'h0) begin
      failures++; $display("FAIL range_fetch: got ready=%b data=%h required 1 00000000", i_ready, i_rdata);
    end
    tick();
  endtask
`else
  task automatic test_wrap();
    int ra, wc; logic [31:0] rd; logic er; logic [10:0] wa; logic [3:0] wb;
    logic [31:0] exp;
    exp_q.push_back(32'hDEADBEEF);
    run_data(1'b0, 32'h10012010, 1'b0, 4'hF, 32'h0, ra, wc, rd, er, wa, wb);
    exp = exp_q.pop_front();
    $display("wrap_load: ready_at=%0d err=%b data=%h", ra, er, rd);
    checks++;
    if (ra !== 3 || er !== 1'b0 || rd !== exp) begin
      failures++; $display("FAIL wrap_load: got ready_at=%0d err=%b data=%h required 3 0 %h", ra, er, rd, exp);
    end
    exp_q.push_back(fetch_model(32'h00402008));
    i_addr = 32'h00402008; i_req = 1'b1;
    tick();
    i_req = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (i_ready !== 1'b1 || i_rdata !== exp) begin
      failures++; $display("FAIL wrap_fetch: got ready=%b data=%h required 1 %h", i_ready, i_rdata, exp);
    end
    tick();
  endtask
`endif

  task automatic test_reset_in_acc();
    d_addr = 32'h10010030; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'h55AA55AA; d_req = 1'b1;
    tick();
    d_req = 1'b0;
    tick();
    checks++;
    if (dmem_we !== 1'b1) begin
      failures++; $display("FAIL acc_strobe: got %b required 1", dmem_we);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dmem_we !== 1'b0) begin
      failures++; $display("FAIL acc_reset_we: got %b required 0", dmem_we);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (dmem[12] !== 32'h0 || d_ready !== 1'b0) begin
      failures++; $display("FAIL acc_reset_nowrite: got mem=%h ready=%b required 0 0", dmem[12], d_ready);
    end
    $display("reset_in_acc: mem=%h", dmem[12]);
  endtask

  task automatic test_mid_reset();
    int ra, wc; logic [31:0] rd; logic er; logic [10:0] wa; logic [3:0] wb;
    logic seen = 1'b0;
    logic [31:0] exp;
    d_addr = 32'h10010020; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'h12345678; d1_req = 1'b1;
    tick();
    d1_req = 1'b0;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (dmem1_we || d1_ready) seen = 1'b1;
      tick();
    end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dmem1_we || d1_ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || dmem1[8] !== 32'h0) begin
      failures++; $display("FAIL mid_reset_abort: got activity=%b mem=%h required 0 00000000", seen, dmem1[8]);
    end
    run_data(1'b1, 32'h10010020, 1'b1, 4'hF, 32'h12345678, ra, wc, rd, er, wa, wb);
    $display("mid_reset_store: ready_at=%0d we_cnt=%0d mem=%h", ra, wc, dmem1[8]);
    checks++;
    if (ra !== 5 || wc !== 1 || dmem1[8] !== 32'h12345678) begin
      failures++; $display("FAIL mid_reset_store: got ready_at=%0d we_cnt=%0d mem=%h required 5 1 12345678", ra, wc, dmem1[8]);
    end
    exp_q.push_back(32'h12345678);
    run_data(1'b1, 32'h10010020, 1'b0, 4'hF, 32'h0, ra, wc, rd, er, wa, wb);
    exp = exp_q.pop_front();
    checks++;
    if (ra !== 5 || rd !== exp) begin
      failures++; $display("FAIL mid_reset_load: got ready_at=%0d data=%h required 5 %h", ra, rd, exp);
    end
    $display("mid_reset_load: data=%h", rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; init_mem = 1'b1; i_addr = '0; i_req = 1'b0;
    d_addr = '0; d_req = 1'b0; d1_req = 1'b0; d_we = 1'b0; d_be = '0; d_wdata = '0;
    test_reset();
    test_fetch();
    test_store_load();
    test_byte_store();
    test_concurrent();
`ifdef ACCESS_ERR_EN
    test_errors();
`else
    test_wrap();
`endif
    test_reset_in_acc();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sccomp_mem_bridge.md
Name: sccomp_mem_bridge

Overview:
- Parametrised memory-side bridge between the single-cycle/multicycle CPU core and the instruction and data memories.
- Replaces fixed-offset, divide-by-4 address mapping with configurable segment bases and depths.
- Adds a request/ready handshake with programmable wait states, plus byte-lane writes.
- Sits in the top-level dataflow wrapper, between the cpu instance and the imem/dmem instances.

Parameters:
IBASE, 32'h00400000, byte base address of the instruction segment
DBASE, 32'h10010000, byte base address of the data segment
IAW, 11, word-address width of imem (depth 2^IAW words)
DAW, 11, word-address width of dmem (depth 2^DAW words)
DWAIT, 1, extra wait cycles per data access (0..15)

Ports:
clk_in  input  1  clock; all state updates on posedge
reset  input  1  synchronous active-low reset (0: reset, 1: run)
i_addr  input  32  CPU fetch byte address
i_req  input  1  fetch request
i_rdata  output  32  fetched instruction
i_ready  output  1  fetch complete, i_rdata valid
d_addr  input  32  CPU data byte address
d_req  input  1  data access request
d_we  input  1  1 = store, 0 = load
d_be  input  4  byte enables for stores
d_wdata  input  32  store data
d_rdata  output  32  load data
d_ready  output  1  data access complete
d_err  output  1  access fault (out of range or misaligned)
imem_addr  output  IAW  imem word address
imem_rdata  input  32  imem read data (combinational)
dmem_addr  output  DAW  dmem word address
dmem_we  output  1  dmem write strobe
dmem_be  output  4  dmem byte enables
dmem_wdata  output  32  dmem write data
dmem_rdata  input  32  dmem read data (combinational)

Behaviour:
- Reset (reset==0 at posedge): all outputs 0; data FSM to D_IDLE; wait counter 0.
- Address mapping:
  - imem_addr = (i_addr - IBASE)[IAW+1:2].
  - dmem_addr = (d_addr - DBASE)[DAW+1:2].
  - Offsets are computed as 32-bit unsigned values.
  - An offset is in range when it is < 4*2^DEPTH.
- Fetch path, fixed 1-cycle latency:
  - If i_req is high at posedge, then on the next cycle i_rdata is registered from imem_rdata and i_ready=1 for exactly one cycle.
  - Back-to-back requests give i_ready every cycle.
- Data FSM:
  - D_IDLE:
    - d_req=1: latch addr/we/be/wdata and load the counter with DWAIT.
    - Next state is D_WAIT if DWAIT>0, else D_ACC.
  - D_WAIT: decrement the counter; go to D_ACC when it reaches 1.
  - D_ACC:
    - Store: dmem_we=1 for exactly this one cycle, with dmem_be = latched be.
    - Load: capture dmem_rdata into d_rdata.
    - Go to D_RESP.
  - D_RESP: d_ready=1 for one cycle; return to D_IDLE.
  - Total latency, request to d_ready: DWAIT+2 cycles.
- d_req while not in D_IDLE is ignored; the CPU must hold off until d_ready.
- d_rdata holds its last value until the next load completes.
- Misalignment:
  - Word access with d_be==4'b1111 requires d_addr[1:0]==0.
  - Partial d_be is always legal.
- Mid-operation reset: the FSM aborts to D_IDLE immediately and dmem_we is forced to 0 in that cycle; no partial write occurs.
- Simultaneous fetch and data request: the two paths are independent and both proceed.

Optional Feature:
ACCESS_ERR_EN
- Defined:
  - An out-of-range or misaligned data access skips D_ACC: no dmem_we, and d_rdata is unchanged.
  - The FSM goes straight to D_RESP with d_ready=1 and d_err=1 for that cycle.
  - Out-of-range fetches return i_rdata=32'h00000000 (nop).
- Undefined:
  - No range or alignment checks; d_err tied to 0.
  - Addresses are truncated to IAW/DAW bits and the memories wrap around.

Test Plan:
- Reset: reset=0 for 2 cycles with d_req=1, d_we=1 -> dmem_we never asserted; all outputs 0; FSM idle after release.
- Fetch: i_addr=32'h00400008, i_req=1 -> imem_addr=2; next cycle i_ready=1 and i_rdata=imem word 2; back-to-back requests to 0x0040000C and 0x00400010 give consecutive i_ready.
- Store then load, DWAIT=1:
  - Store d_addr=32'h10010010, d_wdata=32'hDEADBEEF, d_be=4'b1111 -> dmem_addr=4; dmem_we high exactly one cycle; d_ready on cycle 3.
  - Load from the same address -> d_rdata=32'hDEADBEEF.
- Byte store: d_addr=32'h10010001, d_be=4'b0010 -> dmem_be=4'b0010, dmem_addr=0, no error.
- With ACCESS_ERR_EN:
  - Word load at 32'h10010002 -> d_err=1 with d_ready, no dmem access.
  - Load at DBASE+4*2^DAW -> d_err=1.
- Mid-operation reset: assert reset=0 during D_WAIT (DWAIT=3) -> no dmem_we, no d_ready; a new request after release completes normally.
